// File: rtl/key_schedule.sv
// RC4 key-scheduling engine: initialises S to the identity, then runs the
// 256-step swap shuffle driven by a 24-bit key through a 1-cycle-latency RAM port.
module key_schedule (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic [7:0]  s_memory_address,
    output logic [7:0]  s_memory_data,
    output logic        s_memory_write_enable,
    input  logic [7:0]  s_memory_q,
    output logic        finish
);

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StReadI,
        StLatchI,
        StReadJ,
        StLatchJ,
        StWriteI,
        StWriteJ,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [1:0]  k_q, k_d;     // i mod 3, selects the key byte
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  key_byte;

    // Key byte for the current i: key[0] is the most significant byte.
    always_comb begin
        unique case (k_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 2'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            key_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
        end
    end

    // Next-state logic; outputs depend only on state and registers, never on s_memory_q.
    always_comb begin
        state_d               = state_q;
        i_d                   = i_q;
        j_d                   = j_q;
        k_d                   = k_q;
        si_d                  = si_q;
        sj_d                  = sj_q;
        key_d                 = key_q;
        s_memory_address      = 8'd0;
        s_memory_data         = 8'd0;
        s_memory_write_enable = 1'b0;
        finish                = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = secret_key;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = 2'd0;
                    state_d = StInit;
                end
            end
            StInit: begin
                s_memory_address      = i_q;
                s_memory_data         = i_q;
                s_memory_write_enable = 1'b1;
                i_d                   = i_q + 8'd1;  // wraps to 0 after 255
                if (i_q == 8'hff) begin
                    k_d     = 2'd0;
                    state_d = StReadI;
                end
            end
            StReadI: begin
                s_memory_address = i_q;
                state_d          = StLatchI;
            end
            StLatchI: begin
                s_memory_address = i_q;
                si_d             = s_memory_q;
                j_d              = j_q + s_memory_q + key_byte;
                state_d          = StReadJ;
            end
            StReadJ: begin
                s_memory_address = j_q;
                state_d          = StLatchJ;
            end
            StLatchJ: begin
                s_memory_address = j_q;
                sj_d             = s_memory_q;
                state_d          = StWriteI;
            end
            StWriteI: begin
                s_memory_address      = i_q;
                s_memory_data         = sj_q;
                s_memory_write_enable = 1'b1;
                state_d               = StWriteJ;
            end
            StWriteJ: begin
                s_memory_address      = j_q;
                s_memory_data         = si_q;
                s_memory_write_enable = 1'b1;
                if (i_q == 8'hff) begin
                    state_d = StDone;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
                    state_d = StReadI;
                end
            end
            StDone: begin
                finish = 1'b1;
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: behavioural RAM plus a software KSA reference.
module tb_key_schedule;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  s_memory_address;
    logic [7:0]  s_memory_data;
    logic        s_memory_write_enable;
    logic [7:0]  s_memory_q;
    logic        finish;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_schedule dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .secret_key            (secret_key),
        .s_memory_address      (s_memory_address),
        .s_memory_data         (s_memory_data),
        .s_memory_write_enable (s_memory_write_enable),
        .s_memory_q            (s_memory_q),
        .finish                (finish)
    );

    // 256x8 RAM, 1-cycle read latency; scramble fills it with junk between runs.
    logic [7:0] mem [256];
    logic       scramble = 1'b0;
    always @(posedge clk) begin
        if (scramble) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'($urandom);
        end else if (s_memory_write_enable) begin
            mem[s_memory_address] <= s_memory_data;
        end
        s_memory_q <= mem[s_memory_address];
    end

    // Per-cycle trace of the most recent run (cycle 0 = first INIT cycle).
    int          tr_we   [2000];
    int          tr_addr [2000];
    int          tr_data [2000];
    logic [15:0] wr_q [$];      // {address, data} of every write, in order

    // Reference results.
    logic [7:0]  exp_s [256];
    logic [15:0] exp_wr [$];

    // Software RC4 KSA recording every write it implies.
    task automatic model_ksa(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] t;
        int j;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        exp_wr.delete();
        for (int i = 0; i < 256; i++) begin
            s[i] = i[7:0];
            exp_wr.push_back({i[7:0], i[7:0]});
        end
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s[i]) + int'(kb[i % 3])) % 256;
            exp_wr.push_back({i[7:0], s[j]});
            exp_wr.push_back({j[7:0], s[i]});
            t = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        exp_s = s;
    endtask

    // Starts a run (key changes right after the start edge) and traces it until finish.
    task automatic run_capture(input logic [23:0] key, output int fin);
        @(negedge clk);
        scramble = 1'b1;
        @(negedge clk);
        scramble   = 1'b0;
        secret_key = key;
        start      = 1'b1;
        @(negedge clk);
        secret_key = ~key;
        wr_q.delete();
        fin = -1;
        for (int c = 0; c < 2000; c++) begin
            tr_we[c]   = int'(s_memory_write_enable);
            tr_addr[c] = int'(s_memory_address);
            tr_data[c] = int'(s_memory_data);
            if (s_memory_write_enable) wr_q.push_back({s_memory_address, s_memory_data});
            if (finish) begin
                fin = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic stop_run();
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        checks++;
        if ({s_memory_address, s_memory_data, s_memory_write_enable, finish} !== 18'd0) begin
            failures++;
            $display("FAIL reset_initial: addr=%h data=%h we=%b fin=%b, want all 0",
                     s_memory_address, s_memory_data, s_memory_write_enable, finish);
        end
        // Get into INIT so outputs are non-zero, then reset between edges.
        @(negedge clk);
        secret_key = 24'h123456;
        start      = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if ({s_memory_address, s_memory_data, s_memory_write_enable, finish} !== 18'd0) begin
            failures++;
            $display("FAIL reset_async: addr=%h data=%h we=%b fin=%b, want all 0",
                     s_memory_address, s_memory_data, s_memory_write_enable, finish);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_memory_write_enable !== 1'b0 || finish !== 1'b0 || s_memory_address !== 8'd0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_idle_hold: %0d cycles with activity, want 0", bad);
        end
    endtask

    task automatic test_init();
        int fin;
        int bad;
        int nbad;
        model_ksa(24'h000000);
        run_capture(24'h000000, fin);
        bad = -1;
        for (int k = 0; k < 256; k++) begin
            if (bad < 0 && (tr_we[k] != 1 || tr_addr[k] != k || tr_data[k] != k)) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL init_writes: cycle %0d we=%0d addr=%0d data=%0d, want we=1 addr=data=%0d",
                     bad, tr_we[bad], tr_addr[bad], tr_data[bad], bad);
        end
        checks++;
        if (tr_we[256] != 0 || tr_addr[256] != 0) begin
            failures++;
            $display("FAIL init_first_read: cycle 256 we=%0d addr=%0d, want we=0 addr=0",
                     tr_we[256], tr_addr[256]);
        end
        checks++;
        if (fin != 1792) begin
            failures++;
            $display("FAIL init_finish_cycle: finish at cycle %0d, want 1792", fin);
        end
        nbad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) nbad++;
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL init_final_s: %0d bytes differ from reference, want 0", nbad);
        end
        stop_run();
    endtask

    task automatic test_first_swaps();
        int fin;
        logic [15:0] want [4];
        want[0] = 16'h001a;
        want[1] = 16'h1a00;
        want[2] = 16'h011b;
        want[3] = 16'h1b01;
        run_capture(24'h1a0000, fin);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (wr_q.size() < 260 || wr_q[256 + n] !== want[n]) begin
                failures++;
                $display("FAIL first_swap_%0d: got %h, want %h", n,
                         (wr_q.size() >= 260) ? wr_q[256 + n] : 16'hxxxx, want[n]);
            end
        end
        // i=0 writes land in cycles 260 and 261.
        checks++;
        if (tr_we[260] != 1 || tr_addr[260] != 0 || tr_data[260] != 'h1a ||
            tr_we[261] != 1 || tr_addr[261] != 'h1a || tr_data[261] != 0) begin
            failures++;
            $display("FAIL first_swap_timing: c260 we=%0d a=%h d=%h c261 we=%0d a=%h d=%h",
                     tr_we[260], tr_addr[260], tr_data[260], tr_we[261], tr_addr[261],
                     tr_data[261]);
        end
        stop_run();
    endtask

    task automatic test_wrap();
        int fin;
        logic [15:0] want [4];
        want[0] = 16'h00ff;
        want[1] = 16'hff00;
        want[2] = 16'h0100;
        want[3] = 16'hff01;
        run_capture(24'hffffff, fin);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (wr_q.size() < 260 || wr_q[256 + n] !== want[n]) begin
                failures++;
                $display("FAIL wrap_swap_%0d: got %h, want %h", n,
                         (wr_q.size() >= 260) ? wr_q[256 + n] : 16'hxxxx, want[n]);
            end
        end
        stop_run();
    endtask

    task automatic test_handshake();
        int fin;
        int nbad;
        int low;
        model_ksa(24'h000249);
        run_capture(24'h000249, fin);
        checks++;
        if (fin != 1792) begin
            failures++;
            $display("FAIL hs_finish_cycle: finish at cycle %0d, want 1792", fin);
        end
        nbad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) nbad++;
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL hs_final_s: %0d bytes differ from reference, want 0", nbad);
        end
        low = 0;
        repeat (5) begin
            @(negedge clk);
            if (finish !== 1'b1 || s_memory_write_enable !== 1'b0) low++;
        end
        checks++;
        if (low != 0) begin
            failures++;
            $display("FAIL hs_hold: finish dropped or we set in %0d of 5 cycles, want 0", low);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (finish !== 1'b0) begin
            failures++;
            $display("FAIL hs_drop: finish=%b one edge after start low, want 0", finish);
        end
        run_capture(24'h000249, fin);
        checks++;
        if (fin != 1792) begin
            failures++;
            $display("FAIL hs_rerun_cycle: finish at cycle %0d, want 1792", fin);
        end
        nbad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) nbad++;
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL hs_rerun_s: %0d bytes differ from reference, want 0", nbad);
        end
        stop_run();
    endtask

    task automatic test_reset_mid_run();
        int fin;
        int nbad;
        int bad;
        logic [23:0] key;
        key = 24'($urandom);
        @(negedge clk);
        secret_key = key;
        start      = 1'b1;
        @(negedge clk);
        repeat (900) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if ({s_memory_address, s_memory_data, s_memory_write_enable, finish} !== 18'd0) begin
            failures++;
            $display("FAIL midrun_reset: addr=%h data=%h we=%b fin=%b, want all 0",
                     s_memory_address, s_memory_data, s_memory_write_enable, finish);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_memory_write_enable !== 1'b0 || finish !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midrun_idle: %0d active cycles after release, want 0", bad);
        end
        key = 24'($urandom);
        model_ksa(key);
        run_capture(key, fin);
        nbad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) nbad++;
        checks++;
        if (fin != 1792 || nbad != 0) begin
            failures++;
            $display("FAIL midrun_rerun: finish cycle %0d with %0d bad bytes, want 1792 and 0",
                     fin, nbad);
        end
        stop_run();
    endtask

    task automatic test_random_keys();
        int fin;
        int bad;
        int nbad;
        logic [23:0] key;
        for (int r = 0; r < 3; r++) begin
            key = 24'($urandom);
            model_ksa(key);
            run_capture(key, fin);
            bad = -1;
            if (wr_q.size() == exp_wr.size()) begin
                for (int n = 0; n < wr_q.size(); n++)
                    if (bad < 0 && wr_q[n] !== exp_wr[n]) bad = n;
            end else begin
                bad = 99999;
            end
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL rand_writes key=%h: %0d writes, first diff at %0d, want %0d exact",
                         key, wr_q.size(), bad, exp_wr.size());
            end
            nbad = 0;
            for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) nbad++;
            checks++;
            if (fin != 1792 || nbad != 0) begin
                failures++;
                $display("FAIL rand_final key=%h: finish cycle %0d bad bytes %0d, want 1792 and 0",
                         key, fin, nbad);
            end
            stop_run();
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        secret_key = 24'd0;
        #1;
        test_reset();
        test_init();
        test_first_swaps();
        test_wrap();
        test_handshake();
        test_reset_mid_run();
        test_random_keys();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
